button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
- REQ-001: Parameter STABLE_CYCLES, default 1_000: consecutive synchronized clk samples required to accept a level change.
- REQ-002: Parameter LONG_CYCLES, default 500_000: clk cycles held in PRESSED before long_press fires.
- REQ-003: Parameter SYNC_STAGES, default 2: flip-flop stages in the input synchronizer.
- REQ-004: Parameter BTN_ACTIVE_LOW, default 1: 1 means btn_in=0 is "pressed".
- REQ-005: clk  input  1  system clock, the Gowin_OSC-derived clock; single clock domain.
- REQ-006: rst  input  1  synchronous, active-high reset.
- REQ-007: btn_in  input  1  raw, asynchronous push-button pin.
- REQ-008: btn_level  output  1  debounced level, 1 = pressed, independent of polarity.
- REQ-009: btn_press  output  1  one-cycle pulse on an accepted press.
- REQ-010: btn_release  output  1  one-cycle pulse on an accepted release.
- REQ-011: long_press  output  1  one-cycle pulse once per press held LONG_CYCLES.

Function
- REQ-012: btn_in SHALL pass through a SYNC_STAGES-deep flip-flop chain, then be polarity-normalized to "act" (1 = pressed); no other logic SHALL touch btn_in.
- REQ-013: The FSM SHALL have states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus one counter sized $clog2(max(STABLE_CYCLES, LONG_CYCLES))+1 bits.
- REQ-014: IDLE: act=1 -> PRESS_WAIT with counter=1; otherwise stay with counter=0.
- REQ-015: PRESS_WAIT: act=1 increments counter; when counter reaches STABLE_CYCLES -> PRESSED; act=0 at any point -> IDLE with counter=0 and no pulse.
- REQ-016: PRESSED: act=0 -> RELEASE_WAIT with counter=1; otherwise counter counts held cycles and saturates at LONG_CYCLES without wrap.
- REQ-017: RELEASE_WAIT: act=0 increments counter; at STABLE_CYCLES -> IDLE; act=1 -> PRESSED, no pulse, long-press counter restarts from 0 and long_press stays suppressed if it already fired for this press.
- REQ-018: btn_level SHALL be a registered output: 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
- REQ-019: btn_press SHALL be 1 for exactly the single cycle in which btn_level first reads 1; btn_release likewise for the cycle in which btn_level first reads 0.
- REQ-020: long_press SHALL pulse for one cycle when the held count first equals LONG_CYCLES, at most once per accepted press, and never in the same cycle as btn_press.
- REQ-021: Latency: a clean edge on btn_in SHALL change btn_level exactly SYNC_STAGES+STABLE_CYCLES clk edges after the first edge that samples the new value.
- REQ-022: Glitch rejection: any act pulse or gap shorter than STABLE_CYCLES cycles SHALL leave all outputs unchanged.
- REQ-023: btn_press and btn_release SHALL never both be 1 in the same cycle.
- REQ-024: Elaboration SHALL fail ($error) unless STABLE_CYCLES>=2, SYNC_STAGES>=2 and LONG_CYCLES>STABLE_CYCLES.

Reset
- REQ-025: While rst=1 at a clk edge, state SHALL become IDLE, counter 0, synchronizer flops the inactive level, and btn_level, btn_press, btn_release and long_press 0.
- REQ-026: Reset asserted mid-press (any state) SHALL drop btn_level with no btn_release pulse.
- REQ-027: After reset release with the button already held, a full press SHALL be qualified: btn_press follows after SYNC_STAGES+STABLE_CYCLES edges.

Verification (STABLE_CYCLES=4, LONG_CYCLES=10, SYNC_STAGES=2, BTN_ACTIVE_LOW=1)
- REQ-028: btn_in 1->0 held -> btn_level=1 and btn_press=1 exactly 6 edges later; btn_press=0 on the next cycle.
- REQ-029: btn_in low for 3 cycles then high -> btn_level, btn_press and btn_release stay 0 throughout.
- REQ-030: Press held for 20 cycles after acceptance -> a single long_press pulse 10 cycles after btn_press and no second pulse.
- REQ-031: While pressed, btn_in high for 2 cycles then low again -> no btn_release and btn_level stays 1; a later high for 4+ cycles -> one btn_release 6 edges after the edge.
- REQ-032: rst=1 for one cycle during PRESSED -> all outputs 0 the next cycle, no btn_release, and a new press is re-qualified after release of rst.
- REQ-033: Chatter of 10 alternating single-cycle toggles ending low -> exactly one btn_press, 6 edges after the last toggle.

Source files
------------

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Synchronizes a raw push-button pin and debounces it with a four-state FSM.
//   It produces a polarity-independent debounced level and one-cycle press and
//   release pulses. It also produces a one-cycle long-press pulse, at most once
//   per accepted press.
//
// Parameters
//   STABLE_CYCLES  consecutive synchronized samples needed to accept a change
//   LONG_CYCLES    held cycles in PRESSED before long_press fires
//   SYNC_STAGES    depth of the input synchronizer
//   BTN_ACTIVE_LOW 1: btn_in=0 means pressed
//
// Ports
//   clk          system clock (single domain)
//   rst          synchronous, active-high reset
//   btn_in       raw asynchronous button pin
//   btn_level    debounced level, 1 = pressed (registered)
//   btn_press    one-cycle pulse on the first cycle btn_level reads 1
//   btn_release  one-cycle pulse on the first cycle btn_level reads 0
//   long_press   one-cycle pulse once per press held LONG_CYCLES
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int STABLE_CYCLES  = 1_000,
    parameter int LONG_CYCLES    = 500_000,
    parameter int SYNC_STAGES    = 2,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic long_press
);

    localparam int CNT_MAX = (LONG_CYCLES > STABLE_CYCLES) ? LONG_CYCLES : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX    = CNT_W'(LONG_CYCLES);

    // Pin level that means "not pressed"; also the synchronizer reset value.
    localparam logic INACTIVE = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    generate
        if ((STABLE_CYCLES < 2) || (SYNC_STAGES < 2) || (LONG_CYCLES <= STABLE_CYCLES)) begin : g_param_check
            $error("button_debouncer: need STABLE_CYCLES>=2, SYNC_STAGES>=2, LONG_CYCLES>STABLE_CYCLES");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   long_fired_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   act_s;
    logic                   level_s;

    // Synchronizer chain: the only logic that ever sees btn_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{INACTIVE}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in};
        end
    end

    // Polarity normalization of the synchronized pin: act=1 means pressed.
    always_comb begin
        act_s = sync_r[SYNC_STAGES-1] ^ INACTIVE;
    end

    // Debounced level implied by the current state.
    always_comb begin
        level_s = (state_r == PRESSED) || (state_r == RELEASE_WAIT);
    end

    // Debounce FSM with registered outputs. The outputs follow the state one
    // clock later, so a level change lands SYNC_STAGES+STABLE_CYCLES edges
    // after the edge that first samples the new pin value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            long_fired_r <= 1'b0;
            btn_level    <= 1'b0;
            btn_press    <= 1'b0;
            btn_release  <= 1'b0;
            long_press   <= 1'b0;
        end else begin
            btn_level   <= level_s;
            btn_press   <= level_s & ~btn_level;
            btn_release <= ~level_s & btn_level;

            // The counter saturates at LONG_MAX, so the fired flag alone keeps
            // the pulse to one per press, including across release glitches.
            if ((state_r == PRESSED) && (cnt_r == LONG_MAX) && !long_fired_r) begin
                long_press   <= 1'b1;
                long_fired_r <= 1'b1;
            end else if (state_r == IDLE) begin
                long_press   <= 1'b0;
                long_fired_r <= 1'b0;
            end else begin
                long_press   <= 1'b0;
                long_fired_r <= long_fired_r;
            end

            case (state_r)
                IDLE: begin
                    if (act_s) begin
                        state_r <= PRESS_WAIT;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= CNT_ZERO;
                    end
                end
                PRESS_WAIT: begin
                    if (!act_s) begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_r <= PRESSED;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!act_s) begin
                        state_r <= RELEASE_WAIT;
                        cnt_r   <= CNT_ONE;
                    end else if (cnt_r != LONG_MAX) begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                RELEASE_WAIT: begin
                    if (act_s) begin
                        // Release glitch: back to pressed, held count restarts.
                        state_r <= PRESSED;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

    localparam int STABLE = 4;
    localparam int LONG   = 10;
    localparam int SYNC   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b1;
    logic btn_level, btn_press, btn_release, long_press;
    logic [3:0] outs;

    int checks   = 0;
    int failures = 0;

    button_debouncer #(
        .STABLE_CYCLES (STABLE),
        .LONG_CYCLES   (LONG),
        .SYNC_STAGES   (SYNC),
        .BTN_ACTIVE_LOW(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    assign outs = {btn_level, btn_press, btn_release, long_press};

    // Reference model: the pressed-ness of the pin arrives SYNC edges late; the
    // accepted level flips after STABLE consecutive disagreeing samples; the
    // visible outputs trail the accepted level by one clock.
    logic act_q[$];
    logic acc_m;
    int   run_m;
    int   held_m;
    bit   reent_m, fired_m, fire_pend_m;
    logic vis_level_m;
    logic [3:0] exp_out;

    task automatic step(input logic b, input logic r);
        logic act_now, lvl, pr, rl, lg;
        btn_in = b;
        rst    = r;
        @(posedge clk);
        if (r) begin
            act_q.delete();
            for (int k = 0; k < SYNC; k++) act_q.push_back(1'b0);
            acc_m = 1'b0; run_m = 0; held_m = 0;
            reent_m = 1'b0; fired_m = 1'b0; fire_pend_m = 1'b0;
            vis_level_m = 1'b0;
            exp_out = 4'b0000;
        end else begin
            act_now = act_q.pop_front();
            act_q.push_back(~b);
            lvl = acc_m;
            pr  = lvl & ~vis_level_m;
            rl  = ~lvl & vis_level_m;
            lg  = fire_pend_m;
            fire_pend_m = 1'b0;
            vis_level_m = lvl;
            exp_out = {lvl, pr, rl, lg};
            if (act_now != acc_m) begin
                run_m++;
                if (run_m == STABLE) begin
                    acc_m = act_now;
                    run_m = 0;
                    if (act_now) begin
                        held_m = 0; reent_m = 1'b0;
                    end else begin
                        fired_m = 1'b0;
                    end
                end else if (acc_m) begin
                    held_m = 0; reent_m = 1'b1;
                end
            end else begin
                run_m = 0;
                if (acc_m) begin
                    if (reent_m) begin
                        reent_m = 1'b0;
                    end else if (held_m < LONG) begin
                        held_m++;
                        if (held_m == LONG && !fired_m) begin
                            fire_pend_m = 1'b1;
                            fired_m = 1'b1;
                        end
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if (outs !== 4'b0000) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=0000", i, outs);
            end
        end
    endtask

    task automatic test_held_through_reset();
        int press_at = -1, rel_at = -1, press_n = 0, rel_n = 0;
        for (int i = 0; i < 22; i++) begin
            step((i < 10) ? 1'b0 : 1'b1, 1'b0);
            checks++;
            if (outs !== exp_out) begin
                failures++;
                $display("FAIL held_reset_model cyc=%0d got=%b exp=%b", i, outs, exp_out);
            end
            if (btn_press === 1'b1) begin press_n++; if (press_at < 0) press_at = i; end
            if (btn_release === 1'b1) begin rel_n++; if (rel_at < 0) rel_at = i - 10; end
        end
        checks++;
        if (press_at != 6 || press_n != 1) begin
            failures++;
            $display("FAIL held_reset_press at=%0d n=%0d exp at=6 n=1", press_at, press_n);
        end
        checks++;
        if (rel_at != 6 || rel_n != 1) begin
            failures++;
            $display("FAIL held_reset_release at=%0d n=%0d exp at=6 n=1", rel_at, rel_n);
        end
    endtask

    task automatic test_press_long();
        int press_at = -1, long_at = -1, press_n = 0, long_n = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (outs !== exp_out) begin
                failures++;
                $display("FAIL press_long_model cyc=%0d got=%b exp=%b", i, outs, exp_out);
            end
            if (btn_press === 1'b1) begin press_n++; if (press_at < 0) press_at = i; end
            if (long_press === 1'b1) begin long_n++; if (long_at < 0) long_at = i; end
            if (i == 7) begin
                checks++;
                if (btn_press !== 1'b0 || btn_level !== 1'b1) begin
                    failures++;
                    $display("FAIL press_pulse_width level=%b press=%b exp level=1 press=0", btn_level, btn_press);
                end
            end
        end
        checks++;
        if (press_at != 6 || press_n != 1) begin
            failures++;
            $display("FAIL press_latency at=%0d n=%0d exp at=6 n=1", press_at, press_n);
        end
        checks++;
        if (long_at != press_at + 10 || long_n != 1) begin
            failures++;
            $display("FAIL long_press at=%0d n=%0d exp at=%0d n=1", long_at, long_n, press_at + 10);
        end
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    endtask

    task automatic test_short_glitch();
        int any_n = 0;
        for (int i = 0; i < 15; i++) begin
            step((i < 3) ? 1'b0 : 1'b1, 1'b0);
            checks++;
            if (outs !== exp_out) begin
                failures++;
                $display("FAIL short_glitch_model cyc=%0d got=%b exp=%b", i, outs, exp_out);
            end
            if (outs !== 4'b0000) any_n++;
        end
        checks++;
        if (any_n != 0) begin
            failures++;
            $display("FAIL short_glitch_quiet active_cycles=%0d exp=0", any_n);
        end
    endtask

    task automatic test_release_glitch();
        int rel_n = 0, drop_n = 0, rel_at = -1;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            step((i < 2) ? 1'b1 : 1'b0, 1'b0);
            checks++;
            if (outs !== exp_out) begin
                failures++;
                $display("FAIL release_glitch_model cyc=%0d got=%b exp=%b", i, outs, exp_out);
            end
            if (btn_release === 1'b1) rel_n++;
            if (btn_level !== 1'b1) drop_n++;
        end
        checks++;
        if (rel_n != 0 || drop_n != 0) begin
            failures++;
            $display("FAIL release_glitch_hold releases=%0d drops=%0d exp 0 0", rel_n, drop_n);
        end
        rel_n = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (outs !== exp_out) begin
                failures++;
                $display("FAIL release_model cyc=%0d got=%b exp=%b", i, outs, exp_out);
            end
            if (btn_release === 1'b1) begin rel_n++; if (rel_at < 0) rel_at = i; end
        end
        checks++;
        if (rel_at != 6 || rel_n != 1) begin
            failures++;
            $display("FAIL release_latency at=%0d n=%0d exp at=6 n=1", rel_at, rel_n);
        end
    endtask

    task automatic test_reset_mid_press();
        int press_at = -1, rel_n = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b exp=0000", outs);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (outs !== exp_out) begin
                failures++;
                $display("FAIL mid_reset_model cyc=%0d got=%b exp=%b", i, outs, exp_out);
            end
            if (btn_release === 1'b1) rel_n++;
            if (btn_press === 1'b1 && press_at < 0) press_at = i;
        end
        checks++;
        if (press_at != 6 || rel_n != 0) begin
            failures++;
            $display("FAIL mid_reset_requalify press_at=%0d releases=%0d exp 6 0", press_at, rel_n);
        end
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    endtask

    task automatic test_chatter();
        int press_at = -1, press_n = 0, early_n = 0;
        for (int i = 0; i < 10; i++) begin
            step((i % 2 == 1) ? 1'b1 : 1'b0, 1'b0);
            checks++;
            if (outs !== exp_out) begin
                failures++;
                $display("FAIL chatter_model cyc=%0d got=%b exp=%b", i, outs, exp_out);
            end
            if (outs !== 4'b0000) early_n++;
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (outs !== exp_out) begin
                failures++;
                $display("FAIL chatter_settle_model cyc=%0d got=%b exp=%b", i, outs, exp_out);
            end
            if (btn_press === 1'b1) begin press_n++; if (press_at < 0) press_at = i; end
        end
        checks++;
        if (press_at != 6 || press_n != 1 || early_n != 0) begin
            failures++;
            $display("FAIL chatter_single_press at=%0d n=%0d early=%0d exp 6 1 0", press_at, press_n, early_n);
        end
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic b;
        int len;
        for (int s = 0; s < 80; s++) begin
            b   = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 30)) : int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                step(b, ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
                checks++;
                if (outs !== exp_out || (btn_press === 1'b1 && btn_release === 1'b1)) begin
                    failures++;
                    $display("FAIL random_model seg=%0d cyc=%0d got=%b exp=%b", s, i, outs, exp_out);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_held_through_reset();
        test_press_long();
        test_short_glitch();
        test_release_glitch();
        test_reset_mid_press();
        test_chatter();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
